// File: rtl/commit_trace_gen.sv
// commit_trace_gen: classifies retiring instructions into trace events and queues them in a
// DEPTH-entry FIFO, sequencing RUN -> DRAIN -> DONE around HALT. Macro TRACE_CYCLE_STAMP_EN adds trc_cycle.
module commit_trace_gen #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [15:0] wb_pc,
  input  logic        wb_reg_write,
  input  logic [3:0]  wb_write_reg,
  input  logic [15:0] wb_write_data,
  input  logic        wb_mem_read,
  input  logic        wb_mem_write,
  input  logic [15:0] wb_mem_addr,
  input  logic [15:0] wb_mem_data,
  input  logic        wb_halt,
  input  logic        trc_ready,
  output logic        trc_valid,
  output logic [1:0]  trc_kind,
  output logic [15:0] trc_inum,
  output logic [15:0] trc_pc,
  output logic [3:0]  trc_reg,
  output logic [15:0] trc_value,
  output logic [15:0] trc_addr,
  output logic        trc_is_load,
  output logic        stall_req,
  output logic        overflow,
  output logic        done,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [31:0] trc_cycle,
`endif
  output logic [1:0]  dbgState
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] KIND_NOP   = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;
  localparam logic [1:0] KIND_HALT  = 2'd3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } stateT;

  typedef struct packed {
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] cycle;
`endif
    logic [1:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
    logic        isLoad;
  } entryT;

  entryT         mem [DEPTH];
  entryT         newEntry;
  entryT         headEntry;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [15:0]   inumCnt;
  stateT         state;
  stateT         stateNext;
  logic          full;
  logic          empty;
  logic          accepting;
  logic          push;
  logic          pop;
  logic          drop;

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cycleCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) cycleCnt <= '0;
    else        cycleCnt <= cycleCnt + 32'd1;
  end
`endif

  // Priority: register write beats HALT beats store; anything else is a NOP/branch.
  always_comb begin
    newEntry      = '0;
    newEntry.pc   = wb_pc;
    newEntry.inum = inumCnt;
`ifdef TRACE_CYCLE_STAMP_EN
    newEntry.cycle = cycleCnt;
`endif
    if (wb_reg_write) begin
      newEntry.kind   = KIND_REG;
      newEntry.rd     = wb_write_reg;
      newEntry.value  = wb_write_data;
      newEntry.isLoad = wb_mem_read;
      newEntry.addr   = wb_mem_read ? wb_mem_addr : 16'h0000;
    end else if (wb_halt) begin
      newEntry.kind = KIND_HALT;
    end else if (wb_mem_write) begin
      newEntry.kind  = KIND_STORE;
      newEntry.addr  = wb_mem_addr;
      newEntry.value = wb_mem_data;
    end else begin
      newEntry.kind = KIND_NOP;
    end
  end

  // Handshake: trc_valid means the head entry is present; it transfers on a rising edge
  // where trc_valid && trc_ready, and trc_* hold steady while trc_valid && !trc_ready.
  // A push into an empty FIFO is always stored, never bypassed to the outputs.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop       = !empty && trc_ready;
  assign accepting = wb_valid && (state == RUN);
  assign push      = accepting && (!full || pop);
  assign drop      = accepting && full && !pop;
  assign headEntry = empty ? entryT'('0) : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      inumCnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + PW'(1);
        inumCnt <= inumCnt + 16'd1;
      end
      if (pop) rdPtr <= rdPtr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= newEntry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (push && newEntry.kind == KIND_HALT) stateNext = DRAIN;
      DRAIN:   if (pop && headEntry.kind == KIND_HALT) stateNext = DONE;
      DONE:    stateNext = DONE;
      default: stateNext = RUN;
    endcase
  end

  assign trc_valid   = !empty;
  assign trc_kind    = headEntry.kind;
  assign trc_inum    = headEntry.inum;
  assign trc_pc      = headEntry.pc;
  assign trc_reg     = headEntry.rd;
  assign trc_value   = headEntry.value;
  assign trc_addr    = headEntry.addr;
  assign trc_is_load = headEntry.isLoad;
`ifdef TRACE_CYCLE_STAMP_EN
  assign trc_cycle   = headEntry.cycle;
`endif
  assign stall_req   = full;
  assign done        = (state == DONE);
  assign dbgState    = state;

endmodule

// File: tb/tb_commit_trace_gen.sv
// tb_commit_trace_gen: directed and random retire traffic with a queue scoreboard on trace output.
// Build with TRACE_CYCLE_STAMP_EN to also cover the trc_cycle stamp.
module tb_commit_trace_gen;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [15:0] wb_pc;
  logic        wb_reg_write;
  logic [3:0]  wb_write_reg;
  logic [15:0] wb_write_data;
  logic        wb_mem_read;
  logic        wb_mem_write;
  logic [15:0] wb_mem_addr;
  logic [15:0] wb_mem_data;
  logic        wb_halt;
  logic        trc_ready;
  logic        trc_valid;
  logic [1:0]  trc_kind;
  logic [15:0] trc_inum;
  logic [15:0] trc_pc;
  logic [3:0]  trc_reg;
  logic [15:0] trc_value;
  logic [15:0] trc_addr;
  logic        trc_is_load;
  logic        stall_req;
  logic        overflow;
  logic        done;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] trc_cycle;
`endif
  logic [1:0]  dbgState;

  logic [70:0] exp_q[$];
  logic [15:0] tbInum;
  int          nChecks;
  int          nFails;

  commit_trace_gen #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write), .wb_mem_addr(wb_mem_addr),
    .wb_mem_data(wb_mem_data), .wb_halt(wb_halt), .trc_ready(trc_ready),
    .trc_valid(trc_valid), .trc_kind(trc_kind), .trc_inum(trc_inum), .trc_pc(trc_pc),
    .trc_reg(trc_reg), .trc_value(trc_value), .trc_addr(trc_addr), .trc_is_load(trc_is_load),
    .stall_req(stall_req), .overflow(overflow), .done(done),
`ifdef TRACE_CYCLE_STAMP_EN
    .trc_cycle(trc_cycle),
`endif
    .dbgState(dbgState)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference classification, written from the event-kind rules
  function automatic logic [70:0] mk_exp(input logic rw, input logic hlt, input logic mr,
                                         input logic mw, input logic [15:0] pc,
                                         input logic [3:0] rd, input logic [15:0] wd,
                                         input logic [15:0] ma, input logic [15:0] md,
                                         input logic [15:0] inum);
    logic [1:0]  k;
    logic [3:0]  r;
    logic [15:0] v;
    logic [15:0] a;
    logic        ld;
    k = 2'd0; r = 4'h0; v = 16'h0; a = 16'h0; ld = 1'b0;
    if (rw) begin
      k = 2'd1; r = rd; v = wd; ld = mr; a = mr ? ma : 16'h0000;
    end else if (hlt) begin
      k = 2'd3;
    end else if (mw) begin
      k = 2'd2; a = ma; v = md;
    end
    return {k, inum, pc, r, v, a, ld};
  endfunction

  // Scoreboard: compare each transfer against the oldest expected entry
  always @(negedge clk) begin
    logic [70:0] got;
    logic [70:0] e;
    if (rst_n === 1'b1 && trc_valid === 1'b1 && trc_ready === 1'b1) begin
      got = {trc_kind, trc_inum, trc_pc, trc_reg, trc_value, trc_addr, trc_is_load};
      nChecks++;
      if (exp_q.size() == 0) begin
        nFails++;
        $display("FAIL scoreboard_unexpected: got=%h required=no transfer", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          nFails++;
          $display("FAIL scoreboard_entry: got=%h required=%h", got, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    wb_valid = 1'b0; wb_pc = 16'h0; wb_reg_write = 1'b0; wb_write_reg = 4'h0;
    wb_write_data = 16'h0; wb_mem_read = 1'b0; wb_mem_write = 1'b0;
    wb_mem_addr = 16'h0; wb_mem_data = 16'h0; wb_halt = 1'b0;
  endtask

  task automatic send(input logic rw, input logic hlt, input logic mr, input logic mw,
                      input logic [15:0] pc, input logic [3:0] rd, input logic [15:0] wd,
                      input logic [15:0] ma, input logic [15:0] md, input bit acc);
    wb_valid = 1'b1; wb_reg_write = rw; wb_halt = hlt; wb_mem_read = mr; wb_mem_write = mw;
    wb_pc = pc; wb_write_reg = rd; wb_write_data = wd; wb_mem_addr = ma; wb_mem_data = md;
    if (acc) begin
      exp_q.push_back(mk_exp(rw, hlt, mr, mw, pc, rd, wd, ma, md, tbInum));
      tbInum = tbInum + 16'd1;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    trc_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    tbInum = 16'h0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || trc_valid !== 1'b0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    nChecks++;
    if (exp_q.size() != 0 || trc_valid !== 1'b0) begin
      nFails++;
      $display("FAIL %s_drain: pending=%0d trc_valid=%b required pending=0 trc_valid=0",
               tag, exp_q.size(), trc_valid);
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    idle_inputs();
    trc_ready = 1'b1;
    rst_n = 1'b0;
    wb_valid = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if ({trc_valid, stall_req, overflow, done} !== 4'b0000) begin
      nFails++;
      $display("FAIL reset_flags: valid/stall/ovf/done=%b required 0000",
               {trc_valid, stall_req, overflow, done});
    end
    @(posedge clk); #1;
    nChecks++;
    if ({trc_kind, trc_inum, trc_pc, trc_value, trc_addr} !== 66'h0 || dbgState !== 2'd0) begin
      nFails++;
      $display("FAIL reset_outputs: kind=%h inum=%h pc=%h state=%0d required all zero",
               trc_kind, trc_inum, trc_pc, dbgState);
    end
    wb_valid = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    tbInum = 16'h0;
    @(posedge clk); #1;
    nChecks++;
    if (trc_valid !== 1'b0) begin
      nFails++;
      $display("FAIL reset_release_valid: got=%b required=0", trc_valid);
    end
  endtask

  task automatic test_reg();
    do_reset();
    trc_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 4'd3, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    nChecks++;
    if (trc_valid !== 1'b1 || trc_kind !== 2'd1 || trc_inum !== 16'h0 ||
        trc_reg !== 4'd3 || trc_value !== 16'h1234) begin
      nFails++;
      $display("FAIL reg_latency: valid=%b kind=%0d inum=%h reg=%0d value=%h required 1 1 0000 3 1234",
               trc_valid, trc_kind, trc_inum, trc_reg, trc_value);
    end
    wait_drain("reg");
  endtask

  task automatic test_load_store();
    do_reset();
    trc_ready = 1'b1;
    send(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 4'd5, 16'hBEEF, 16'h0040, 16'h9999, 1'b1);
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'h0012, 4'd9, 16'h7777, 16'h0010, 16'h00AA, 1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b1, 16'h0014, 4'd2, 16'h4321, 16'h0777, 16'h1111, 1'b1);
    send(1'b0, 1'b0, 1'b1, 1'b0, 16'h0016, 4'd6, 16'h5555, 16'h0888, 16'h2222, 1'b1);
    wait_drain("load_store");
  endtask

  task automatic test_overflow();
    logic [70:0] held;
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(i), 4'h0, 16'h0, 16'h0, 16'h0, 1'b1);
      nChecks++;
      if (stall_req !== (i == DEPTH - 1)) begin
        nFails++;
        $display("FAIL overflow_stall_fill%0d: got=%b required=%b", i, stall_req, (i == DEPTH - 1));
      end
    end
    send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0200, 4'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    nChecks++;
    if (overflow !== 1'b1 || stall_req !== 1'b1) begin
      nFails++;
      $display("FAIL overflow_set: ovf=%b stall=%b required 1 1", overflow, stall_req);
    end
    held = {trc_kind, trc_inum, trc_pc, trc_reg, trc_value, trc_addr, trc_is_load};
    repeat (3) begin @(posedge clk); #1; end
    nChecks++;
    if ({trc_kind, trc_inum, trc_pc, trc_reg, trc_value, trc_addr, trc_is_load} !== held ||
        trc_valid !== 1'b1 || trc_pc !== 16'h0100) begin
      nFails++;
      $display("FAIL overflow_stable: got pc=%h inum=%h required pc=0100 inum=0000 unchanged",
               trc_pc, trc_inum);
    end
    trc_ready = 1'b1;
    wait_drain("overflow");
    nChecks++;
    if (overflow !== 1'b1 || stall_req !== 1'b0) begin
      nFails++;
      $display("FAIL overflow_sticky: ovf=%b stall=%b required 1 0", overflow, stall_req);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    trc_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0300 + 16'(i), 4'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    trc_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0380, 4'd7, 16'hCAFE, 16'h0, 16'h0, 1'b1);
    nChecks++;
    if (stall_req !== 1'b1 || overflow !== 1'b0) begin
      nFails++;
      $display("FAIL full_pushpop: stall=%b ovf=%b required 1 0", stall_req, overflow);
    end
    wait_drain("full_pushpop");
  endtask

  task automatic test_halt();
    do_reset();
    trc_ready = 1'b0;
    send(1'b1, 1'b1, 1'b0, 1'b0, 16'h0400, 4'd1, 16'h00F1, 16'h0, 16'h0, 1'b1);
    nChecks++;
    if (dbgState !== 2'd0) begin
      nFails++;
      $display("FAIL halt_reg_priority_state: got=%0d required=0", dbgState);
    end
    send(1'b0, 1'b1, 1'b1, 1'b1, 16'h0402, 4'd4, 16'h1111, 16'h0055, 16'h2222, 1'b1);
    nChecks++;
    if (dbgState !== 2'd1) begin
      nFails++;
      $display("FAIL halt_drain_state: got=%0d required=1", dbgState);
    end
    send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0404, 4'd8, 16'h3333, 16'h0, 16'h0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 1'b1, 16'h0406, 4'd0, 16'h0, 16'h0060, 16'h4444, 1'b0);
    nChecks++;
    if (overflow !== 1'b0 || stall_req !== 1'b0 || done !== 1'b0) begin
      nFails++;
      $display("FAIL halt_ignore: ovf=%b stall=%b done=%b required 0 0 0", overflow, stall_req, done);
    end
    trc_ready = 1'b1;
    wait_drain("halt");
    nChecks++;
    if (done !== 1'b1 || dbgState !== 2'd2) begin
      nFails++;
      $display("FAIL halt_done: done=%b state=%0d required 1 2", done, dbgState);
    end
    send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0408, 4'd3, 16'h5555, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    nChecks++;
    if (trc_valid !== 1'b0 || done !== 1'b1) begin
      nFails++;
      $display("FAIL halt_terminal: valid=%b done=%b required 0 1", trc_valid, done);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    trc_ready = 1'b0;
    send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0500, 4'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    send(1'b0, 1'b0, 1'b0, 1'b0, 16'h0502, 4'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 1'b0, 16'h0504, 4'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    nChecks++;
    if (dbgState !== 2'd1 || trc_valid !== 1'b1) begin
      nFails++;
      $display("FAIL mid_drain_setup: state=%0d valid=%b required 1 1", dbgState, trc_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    nChecks++;
    if (trc_valid !== 1'b0 || done !== 1'b0 || dbgState !== 2'd0 || stall_req !== 1'b0) begin
      nFails++;
      $display("FAIL mid_drain_reset: valid=%b done=%b state=%0d stall=%b required 0 0 0 0",
               trc_valid, done, dbgState, stall_req);
    end
    rst_n = 1'b1;
    exp_q.delete();
    tbInum = 16'h0;
    trc_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0, 16'h0600, 4'd11, 16'h0ABC, 16'h0, 16'h0, 1'b1);
    nChecks++;
    if (trc_valid !== 1'b1 || trc_inum !== 16'h0) begin
      nFails++;
      $display("FAIL mid_drain_restart_inum: valid=%b inum=%h required 1 0000", trc_valid, trc_inum);
    end
`ifdef TRACE_CYCLE_STAMP_EN
    nChecks++;
    if (trc_cycle !== 32'h0) begin
      nFails++;
      $display("FAIL mid_drain_cycle_stamp: got=%h required=00000000", trc_cycle);
    end
`endif
    wait_drain("mid_drain");
  endtask

  task automatic test_random();
    do_reset();
    trc_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain("random");
    nChecks++;
    if (overflow !== 1'b0) begin
      nFails++;
      $display("FAIL random_overflow: got=%b required=0", overflow);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    tbInum  = 16'h0;
    rst_n   = 1'b0;
    trc_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_reg();
    test_load_store();
    test_overflow();
    test_full_pushpop();
    test_halt();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/commit_trace_gen.md
COMMIT_TRACE_GEN -- requirements
Module: commit_trace_gen

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 wb_valid  in  1  an instruction retires this cycle.
REQ-005 wb_pc  in  16  PC of retiring instruction.
REQ-006 wb_reg_write  in  1  retiring instruction writes the register file.
REQ-007 wb_write_reg  in  4  destination register.
REQ-008 wb_write_data  in  16  register write value.
REQ-009 wb_mem_read / wb_mem_write  in  1 each  load / store retiring.
REQ-010 wb_mem_addr  in  16  memory address; wb_mem_data  in  16  store data.
REQ-011 wb_halt  in  1  HLT retiring.
REQ-012 trc_valid  out  1  head FIFO entry present; trc_ready  in  1  consumer accepts.
REQ-013 trc_kind  out  2  0=NOP/branch, 1=REG, 2=STORE, 3=HALT.
REQ-014 trc_inum  out  16  instruction number; trc_pc  out  16.
REQ-015 trc_reg  out  4; trc_value  out  16; trc_addr  out  16; trc_is_load  out  1.
REQ-016 stall_req  out  1  FIFO full, CPU SHALL hold writeback.
REQ-017 overflow  out  1  sticky: an event was dropped.
REQ-018 done  out  1  HALT entry has been consumed.

Function
REQ-019 Event classification priority SHALL be: wb_reg_write -> REG; else wb_halt -> HALT; else wb_mem_write -> STORE; else NOP.
REQ-020 REG: trc_reg/trc_value from wb_write_reg/wb_write_data; trc_is_load=wb_mem_read; trc_addr=wb_mem_addr if load else 0.
REQ-021 STORE: trc_addr=wb_mem_addr, trc_value=wb_mem_data, trc_reg=0; NOP/HALT: reg, value, addr, is_load all 0.
REQ-022 Event with wb_valid=1 in state RUN SHALL be pushed on that edge and visible on trc_* next cycle if FIFO was empty (latency 1).
REQ-023 trc_inum SHALL be a 16-bit counter value at push, starting 0, incrementing per accepted push, wrapping FFFF->0000.
REQ-024 Transfer occurs when trc_valid && trc_ready; trc_* SHALL stay stable while trc_valid && !trc_ready.
REQ-025 stall_req SHALL equal (count==DEPTH), combinationally from registered count.
REQ-026 Push while full and no pop same cycle: event dropped, inum unchanged, overflow set until reset.
REQ-027 Push while full with pop same cycle: push accepted, count unchanged.
REQ-028 Push and pop same cycle when empty: entry SHALL be stored, not bypassed; trc_valid 1 next cycle.
REQ-029 FSM states RUN, DRAIN, DONE: RUN->DRAIN on accepted HALT push; DRAIN->DONE on pop of HALT entry; DONE terminal until reset.
REQ-030 In DRAIN and DONE, wb_valid SHALL be ignored (no push, no overflow); done=1 only in DONE.

Reset
REQ-031 With rst_n=0 at a clock edge: FIFO empty, pointers 0, inum 0, state RUN, overflow 0.
REQ-032 Outputs during/after reset: trc_valid 0, stall_req 0, done 0, trc_* 0; in-flight entries discarded, including mid-DRAIN.

Configuration
REQ-033 Macro TRACE_CYCLE_STAMP_EN defined: output trc_cycle  out  32 present, each entry stamped with a free-running cycle counter (0 on first cycle after reset, increments every clk, wraps).
REQ-034 Macro not defined: trc_cycle port, counter and FIFO field SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset, then REG r3=0x1234 at PC 0x0002, trc_ready=1 -> next cycle trc_valid=1, kind=1, inum=0, reg=3, value=0x1234.
REQ-036 Load r5=0xBEEF addr 0x0040 then store 0x00AA to 0x0010 -> entries kind1 is_load=1 addr=0x0040, then kind2 addr=0x0010 value=0x00AA, inum 0,1.
REQ-037 trc_ready=0, DEPTH=4, five NOPs -> stall_req=1 after 4th, 5th dropped, overflow=1, later drained inums 0..3.
REQ-038 Full FIFO, trc_ready=1 and wb_valid=1 same cycle -> count stays 4, overflow stays 0, new inum=4.
REQ-039 HALT then further wb_valid events -> single kind=3 entry, extra events ignored, done=1 cycle after HALT popped.
REQ-040 rst_n=0 mid-DRAIN with 3 entries -> trc_valid=0, done=0, next event inum=0 (with TRACE_CYCLE_STAMP_EN: trc_cycle restarts at 0).
